// File: rtl/div_signed.sv
// Multi-cycle signed restoring divider, quotient rounded toward zero, remainder takes the dividend's sign.
// Optional macro DIV_ZERO_DETECT_EN adds a dbz output and a one-edge divide-by-zero completion.
module div_signed #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             ready
`ifdef DIV_ZERO_DETECT_EN
  ,
  output logic             dbz
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     dvd;
  logic [WIDTH-1:0]     dvs;
  logic [WIDTH:0]       rem;
  logic [WIDTH:0]       shifted;
  logic [WIDTH:0]       diff;
  logic                 neg;
  logic                 sa;
  logic                 zflag;
  logic                 bzero;
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;

  assign a_s = a;
  assign b_s = b;

`ifdef DIV_ZERO_DETECT_EN
  assign bzero = (b == '0);
`else
  assign bzero = 1'b0;
`endif

  // Magnitude of a two's complement value; the most negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] x);
    abs_val = x[WIDTH-1] ? WIDTH'(-x) : WIDTH'(x);
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] x, input logic s);
    apply_sign = s ? WIDTH'(-x) : x;
  endfunction

  // One restoring step: bring in the next dividend bit and try subtracting the divisor.
  always_comb begin
    shifted = {rem[WIDTH-1:0], dvd[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = bzero ? FIX : DIV;
      DIV:     if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and architecturally visible outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      busy  <= 1'b0;
      ready <= 1'b0;
      q     <= '0;
      r     <= '0;
`ifdef DIV_ZERO_DETECT_EN
      dbz   <= 1'b0;
`endif
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
          end
        end
        DIV: cnt <= cnt + CW'(1);
        FIX: begin
          busy  <= 1'b0;
          ready <= 1'b1;
          if (zflag) begin
            q <= '1;
            r <= apply_sign(dvd, sa);
          end else begin
            q <= apply_sign(dvd, neg);
            r <= apply_sign(rem[WIDTH-1:0], sa);
          end
`ifdef DIV_ZERO_DETECT_EN
          dbz <= zflag;
`endif
        end
        default: ;
      endcase
    end
  end

  // Working datapath: dvd shifts the dividend out and the quotient in.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (start) begin
          dvd   <= abs_val(a_s);
          dvs   <= abs_val(b_s);
          rem   <= '0;
          neg   <= a_s[WIDTH-1] ^ b_s[WIDTH-1];
          sa    <= a_s[WIDTH-1];
          zflag <= bzero;
        end
      end
      DIV: begin
        dvd <= {dvd[WIDTH-2:0], ~diff[WIDTH]};
        rem <= diff[WIDTH] ? shifted : diff;
      end
      default: ;
    endcase
  end

endmodule
